// File: rtl/fifo_read_serializer_pkg.sv
// Shared state encodings for the FIFO read-side serializer.
// No logic and no latency of its own; only type definitions.
// Backpressure is handled entirely in fifo_read_serializer.
package fifo_read_serializer_pkg;

    // Encoding 2'd3 is never entered; the FSM recovers from it to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SERVE = 2'd2
    } ser_state_t;

endpackage

// File: rtl/fifo_read_serializer.sv
// Pops wide FIFO words and streams them out as IN_WIDTH/OUT_WIDTH chunks (LSB chunk first; MSB chunk first with FIFO_SER_MSB_FIRST_EN).
// Latency: pop at cycle t, first chunk valid at t+2; one FETCH bubble per word.
// Backpressure: chunk held stable while out_valid & !out_ready; the next word is popped only on the last handshake.
module fifo_read_serializer
    import fifo_read_serializer_pkg::*;
#(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_empty,
    output logic                 fifo_pop,
    input  logic [IN_WIDTH-1:0]  fifo_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic                 busy
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATIO - 1);

    // Reject widths that do not split into at least two whole chunks.
    if (((IN_WIDTH % OUT_WIDTH) != 0) || (RATIO < 2)) begin : g_bad_cfg
        $error("fifo_read_serializer: IN_WIDTH must be a multiple of OUT_WIDTH with ratio >= 2");
    end

    ser_state_t          state_q, state_d;
    logic [CNT_W-1:0]    chunk_idx_q, chunk_idx_d;
    logic [IN_WIDTH-1:0] word_reg_q, word_reg_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                pop_c;
    logic                hs;

    // Chunk slices of the held word; the index register selects one.
    logic [OUT_WIDTH-1:0] chunks [RATIO];
    for (genvar g = 0; g < RATIO; g++) begin : g_chunk
`ifdef FIFO_SER_MSB_FIRST_EN
        assign chunks[g] = word_reg_q[IN_WIDTH-1-g*OUT_WIDTH -: OUT_WIDTH];
`else
        assign chunks[g] = word_reg_q[g*OUT_WIDTH +: OUT_WIDTH];
`endif
    end

    assign hs = out_valid_q & out_ready;

    // Next-state logic: fetch one word, serve its chunks, pop the next word only on the last handshake.
    always_comb begin
        state_d     = state_q;
        chunk_idx_d = chunk_idx_q;
        word_reg_d  = word_reg_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        pop_c       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pop_c = !fifo_empty;
                if (!fifo_empty) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // FIFO read data is valid exactly one cycle after the pop.
                word_reg_d  = fifo_data;
                chunk_idx_d = '0;
                out_valid_d = 1'b1;
                out_last_d  = 1'b0;
                state_d     = ST_SERVE;
            end
            ST_SERVE: begin
                if (hs) begin
                    if (!out_last_q) begin
                        chunk_idx_d = chunk_idx_q + 1'b1;
                        out_last_d  = ((chunk_idx_q + 1'b1) == LAST_IDX);
                    end else begin
                        chunk_idx_d = '0;
                        out_last_d  = 1'b0;
                        out_valid_d = 1'b0;
                        pop_c       = !fifo_empty;
                        state_d     = fifo_empty ? ST_IDLE : ST_FETCH;
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                chunk_idx_d = '0;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            chunk_idx_q <= '0;
            word_reg_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            chunk_idx_q <= chunk_idx_d;
            word_reg_q  <= word_reg_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    // Outputs are forced quiet while reset is high, including the cycle it is first sampled.
    assign fifo_pop  = pop_c & ~reset;
    assign out_valid = out_valid_q & ~reset;
    assign out_last  = out_last_q & ~reset;
    assign out_data  = reset ? '0 : chunks[chunk_idx_q];
    assign busy      = (state_q != ST_IDLE) & ~reset;

endmodule

// File: tb/tb_fifo_read_serializer.sv
// Bench for fifo_read_serializer: 64/16 instance behind a behavioural FIFO, plus a 48/16 instance.
// Scoreboard of expected chunks filled at push time, drained on each output handshake.
// Exercises full-rate, stalled, idle-return, mid-word reset and ratio-3 wrap cases.
module tb_fifo_read_serializer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          cyc = 0;

    // 64/16 instance
    logic        fifo_empty;
    logic        fifo_pop;
    logic [63:0] fifo_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_last;
    logic        busy;

    // 48/16 instance
    logic        fifo_empty_b = 1'b1;
    logic        fifo_pop_b;
    logic [47:0] fifo_data_b = '0;
    logic        out_valid_b;
    logic        out_ready_b = 1'b1;
    logic [15:0] out_data_b;
    logic        out_last_b;
    logic        busy_b;

    // FIFO model and scoreboard state
    logic [63:0] fifo_mem [$];
    int          fifo_cnt = 0;
    logic        push_vld = 1'b0;
    logic [63:0] push_dat = '0;
    logic        pop_s = 1'b0;
    logic [15:0] exp_dat [$];
    logic        exp_last [$];
    int          ready_mode = 0;
    int          chk_cnt = 0;
    int          err_cnt = 0;
    int          hs_cnt = 0;
    int          pop_cnt = 0;
    logic        stall_prev = 1'b0;
    logic [15:0] prev_dat = '0;
    logic        prev_last = 1'b0;
    logic [15:0] ed;
    logic        el;

    fifo_read_serializer #(.IN_WIDTH(64), .OUT_WIDTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .fifo_data  (fifo_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy)
    );

    fifo_read_serializer #(.IN_WIDTH(48), .OUT_WIDTH(16)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty_b),
        .fifo_pop   (fifo_pop_b),
        .fifo_data  (fifo_data_b),
        .out_valid  (out_valid_b),
        .out_ready  (out_ready_b),
        .out_data   (out_data_b),
        .out_last   (out_last_b),
        .busy       (busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign fifo_empty = (fifo_cnt == 0);

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_chunk64(input logic [63:0] w, input int k);
`ifdef FIFO_SER_MSB_FIRST_EN
        return w[63-16*k -: 16];
`else
        return w[16*k +: 16];
`endif
    endfunction

    function automatic logic [15:0] exp_chunk48(input logic [47:0] w, input int k);
`ifdef FIFO_SER_MSB_FIRST_EN
        return w[47-16*k -: 16];
`else
        return w[16*k +: 16];
`endif
    endfunction

    // Behavioural single-clock FIFO: data registered one cycle after pop.
    always @(posedge clk) begin
        if (reset) begin
            fifo_mem.delete();
            fifo_cnt <= 0;
        end else begin
            if (pop_s && fifo_mem.size() > 0) fifo_data <= fifo_mem.pop_front();
            if (push_vld) fifo_mem.push_back(push_dat);
            fifo_cnt <= fifo_mem.size();
        end
    end

    // out_ready driver: held low, held high, or random per cycle.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1:       out_ready = 1'b1;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: scoreboard compare on handshake, stall stability, pop legality.
    always @(negedge clk) begin
        pop_s = fifo_pop;
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_vld", 64'(out_valid), 64'(1));
                check("stall_dat", 64'(out_data), 64'(prev_dat));
                check("stall_last", 64'(out_last), 64'(prev_last));
            end
            if (out_valid && out_ready) begin
                hs_cnt++;
                check("chunk_expected", 64'(exp_dat.size() != 0), 64'(1));
                if (exp_dat.size() != 0) begin
                    ed = exp_dat.pop_front();
                    el = exp_last.pop_front();
                    check("chunk_dat", 64'(out_data), 64'(ed));
                    check("chunk_last", 64'(out_last), 64'(el));
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_dat   = out_data;
            prev_last  = out_last;
            if (fifo_pop) begin
                pop_cnt++;
                check("pop_while_empty", 64'(fifo_empty), 64'(0));
            end
        end
    end

    task automatic push_word(input logic [63:0] w);
        @(posedge clk);
        #1;
        push_vld = 1'b1;
        push_dat = w;
        for (int k = 0; k < 4; k++) begin
            exp_dat.push_back(exp_chunk64(w, k));
            exp_last.push_back(k == 3);
        end
        @(posedge clk);
        #1;
        push_vld = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int bound);
        bit done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            @(negedge clk);
            if (exp_dat.size() == 0 && !busy && fifo_cnt == 0) done = 1'b1;
        end
        check(tag, 64'(done), 64'(1));
    endtask

    task automatic serve_b(input logic [47:0] w);
        bit got = 1'b0;
        int n = 0;
        @(posedge clk);
        #1;
        fifo_data_b  = w;
        fifo_empty_b = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (fifo_pop_b) got = 1'b1;
        end
        check("t6_pop", 64'(got), 64'(1));
        @(posedge clk);
        #1;
        fifo_empty_b = 1'b1;
        for (int i = 0; i < 20 && n < 3; i++) begin
            @(negedge clk);
            if (out_valid_b && out_ready_b) begin
                check("t6_dat", 64'(out_data_b), 64'(exp_chunk48(w, n)));
                check("t6_last", 64'(out_last_b), 64'(n == 2));
                n++;
            end
        end
        check("t6_chunks", 64'(n), 64'(3));
    endtask

    int p0;
    int t_pop;
    int c0;
    int cl;
    int nhs;
    int nbub;
    int h0;
    bit seen;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_vld", 64'(out_valid), 64'(0));
        check("rst_last", 64'(out_last), 64'(0));
        check("rst_dat", 64'(out_data), 64'(0));
        check("rst_pop", 64'(fifo_pop), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("idle_vld", 64'(out_valid), 64'(0));
        check("idle_busy", 64'(busy), 64'(0));
        check("idle_dat", 64'(out_data), 64'(0));
        check("idle_b_busy", 64'(busy_b), 64'(0));

        // 1: single word at full rate
        ready_mode = 1;
        p0 = pop_cnt;
        push_word(64'h4444_3333_2222_1111);
        wait_drain("t1_drain", 40);
        check("t1_pops", 64'(pop_cnt - p0), 64'(1));

        // 2: three words, one bubble between words
        p0 = pop_cnt;
        c0 = -1; cl = 0; nhs = 0; nbub = 0;
        fork
            begin
                push_word(64'hAAAA_9999_8888_7777);
                push_word(64'hEEEE_DDDD_CCCC_BBBB);
                push_word(64'h0123_4567_89AB_CDEF);
            end
            begin
                for (int i = 0; i < 80 && nhs < 12; i++) begin
                    @(negedge clk);
                    if (c0 < 0 && out_valid) c0 = cyc;
                    if (c0 >= 0) begin
                        if (!out_valid) nbub++;
                        if (out_valid && out_ready) begin
                            nhs++;
                            cl = cyc;
                        end
                    end
                end
            end
        join
        check("t2_chunks", 64'(nhs), 64'(12));
        // 12 chunk cycles plus 2 FETCH bubbles, counted inclusively.
        check("t2_span", 64'(cl - c0 + 1), 64'(14));
        check("t2_bubbles", 64'(nbub), 64'(2));
        wait_drain("t2_drain", 40);
        check("t2_pops", 64'(pop_cnt - p0), 64'(3));

        // 3: random backpressure
        ready_mode = 2;
        for (int i = 0; i < 4; i++) push_word({$urandom, $urandom});
        wait_drain("t3_drain", 400);
        ready_mode = 1;

        // 4: return to idle, then pop on refill
        push_word(64'h5555_6666_7777_8888);
        wait_drain("t4_drain1", 40);
        @(negedge clk);
        check("t4_idle_busy", 64'(busy), 64'(0));
        check("t4_idle_pop", 64'(fifo_pop), 64'(0));
        check("t4_idle_vld", 64'(out_valid), 64'(0));
        push_word(64'h1234_5678_9ABC_DEF0);
        @(negedge clk);
        check("t4_pop_next", 64'(fifo_pop), 64'(1));
        t_pop = cyc;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("t4_first_lat", 64'(cyc - t_pop), 64'(2));
        wait_drain("t4_drain2", 40);

        // 5: reset after the second chunk of a word
        ready_mode = 0;
        push_word(64'hF00D_BEEF_CAFE_0001);
        push_word(64'hDEAD_DEAD_DEAD_DEAD);
        ready_mode = 1;
        h0 = hs_cnt;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (hs_cnt == h0 + 2) seen = 1'b1;
        end
        check("t5_two_chunks", 64'(seen), 64'(1));
        ready_mode = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_dat.delete();
        exp_last.delete();
        @(negedge clk);
        check("t5_rst_vld", 64'(out_valid), 64'(0));
        check("t5_rst_busy", 64'(busy), 64'(0));
        check("t5_rst_pop", 64'(fifo_pop), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("t5_post_vld", 64'(out_valid), 64'(0));
        check("t5_post_busy", 64'(busy), 64'(0));
        check("t5_post_pop", 64'(fifo_pop), 64'(0));
        ready_mode = 1;
        push_word(64'h0BAD_F00D_1357_2468);
        wait_drain("t5_drain", 40);

        // 6: ratio 3, index wraps 2 -> 0 between words
        serve_b(48'hCCCC_BBBB_AAAA);
        serve_b(48'h3333_2222_1111);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
